lane_scheduler: RTL and testbench
=================================

LANE_SCHEDULER -- requirements
Module: lane_scheduler

Interface
REQ-001 Parameter SPEED, default 5: pixels each active note falls per frame.
REQ-002 Parameter Y_TOP, default 35: spawn row (note bottom edge).
REQ-003 Parameter Y_MAX, default 500: row at or beyond which a note expires.
REQ-004 clk  in  1  single system clock; all state on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 frame_tick  in  1  one-cycle pulse per video frame; starts one schedule pass.
REQ-007 spawn_req  in  4  per-lane one-cycle spawn request (lane0=green .. lane3).
REQ-008 slot_active  out  4  per-slot valid flag.
REQ-009 slot_lane  out  8  2-bit lane id per slot, slot k at bits [2k+1:2k].
REQ-010 slot_y  out  40  10-bit bottom row per slot, slot k at bits [10k+9:10k].
REQ-011 miss  out  4  one-cycle per-lane pulse, a note of that lane expired this pass.
REQ-012 full  out  1  high while all 4 slots are active.
REQ-013 pass_done  out  1  one-cycle pulse, schedule pass finished.
REQ-014 overrun  out  1  one-cycle pulse, frame_tick arrived while a pass was running.

Function
REQ-015 Four note slots shall be shared among four lanes; notes per lane are limited only by free slots.
REQ-016 A spawn_req bit shall set that lane's pending bit; pending persists until granted.
REQ-017 A spawn_req bit coinciding with its lane's grant shall leave pending set.
REQ-018 FSM states: IDLE, ADVANCE, SPAWN, DONE; IDLE->ADVANCE on frame_tick; ADVANCE->SPAWN, SPAWN->DONE, DONE->IDLE unconditionally.
REQ-019 frame_tick outside IDLE shall be ignored and shall pulse overrun for one cycle.
REQ-020 ADVANCE: every active slot with y+SPEED >= Y_MAX shall clear active and set miss for its lane; all other active slots take y <= y+SPEED.
REQ-021 Sum y+SPEED shall be computed at 11 bits; no 10-bit wrap shall occur.
REQ-022 SPAWN: at most one grant per pass, chosen round-robin among pending lanes starting at rr_ptr.
REQ-023 Grant shall load the lowest-index inactive slot: active=1, lane=granted lane, y=Y_TOP; clear pending; rr_ptr <= granted lane+1 mod 4.
REQ-024 Slots freed in ADVANCE shall be available to SPAWN of the same pass.
REQ-025 With no free slot, SPAWN shall grant nothing and leave pending and rr_ptr unchanged.
REQ-026 miss shall pulse in DONE (frame_tick at T -> miss, pass_done at T+3); slot outputs final by T+3.
REQ-027 slot_y of an inactive slot shall read Y_TOP; full is combinational from slot_active.

Reset
REQ-028 reset shall immediately force: state IDLE, all slots inactive, slot_lane 0, slot_y Y_TOP, pending 0, rr_ptr 0.
REQ-029 reset shall force miss, full, pass_done, overrun to 0, aborting any pass in progress with no partial update surviving.
REQ-030 spawn_req and frame_tick asserted while reset is high shall be discarded.

Configuration
REQ-031 Macro LANE_SCHED_MISS_CNT_EN defined: adds output miss_count (8 bits), incremented in DONE by popcount(miss), saturating at 255, reset to 0.
REQ-032 Macro LANE_SCHED_MISS_CNT_EN undefined: port miss_count and its logic absent; all other behaviour identical.

Verification
REQ-033 Reset, spawn_req=0001, frame_tick -> slot0 active, lane 0, y=35 at T+3; pass_done at T+3.
REQ-034 One note, 93 further ticks -> y=500 reached at tick 94 (35+93*5): slot freed, miss=0001 pulse, no y overflow.
REQ-035 spawn_req=1111 then 4 ticks -> grants lanes 0,1,2,3 into slots 0..3 in order, full=1 after fourth.
REQ-036 All slots full, spawn_req=0100, tick -> no grant, pending kept; first pass freeing a slot grants lane 2 into it same pass.
REQ-037 frame_tick at T and T+1 -> overrun pulse at T+1, exactly one pass executed.
REQ-038 reset asserted during SPAWN -> all outputs at reset values the same cycle; with LANE_SCHED_MISS_CNT_EN, miss_count=0.

Source files
------------

// File: rtl/lane_scheduler.sv
// Four-slot falling-note scheduler: each frame advances active notes, retires expired ones,
// then grants one pending lane round-robin. Optional miss counter: LANE_SCHED_MISS_CNT_EN.
module lane_scheduler #(
   parameter int SPEED = 5,
   parameter int Y_TOP = 35,
   parameter int Y_MAX = 500
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick,
   input  logic [3:0]  spawn_req,
   output logic [3:0]  slot_active,
   output logic [7:0]  slot_lane,
   output logic [39:0] slot_y,
   output logic [3:0]  miss,
   output logic        full,
   output logic        pass_done,
   output logic        overrun
`ifdef LANE_SCHED_MISS_CNT_EN
   ,
   output logic [7:0]  miss_count
`endif
);

   typedef enum logic [1:0] {IDLE, ADVANCE, SPAWN, DONE} state_t;

   localparam logic [9:0]  L_Y_TOP = 10'(Y_TOP);
   localparam logic [10:0] L_Y_MAX = 11'(Y_MAX);
   localparam logic [10:0] L_SPEED = 11'(SPEED);

   state_t          r_state;
   logic [3:0]      r_active;
   logic [3:0][1:0] r_lane;
   logic [3:0][9:0] r_y;
   logic [3:0]      r_pending;
   logic [1:0]      r_rr;
   logic [3:0]      r_miss_acc;
   logic [3:0]      r_miss;
   logic            r_pass_done;

   logic [3:0][10:0] w_sum;
   logic [3:0]       w_expire;
   logic [3:0]       w_miss_lanes;
   logic             w_grant_vld;
   logic [1:0]       w_grant_lane;
   logic             w_free_vld;
   logic [1:0]       w_free_slot;
   logic             w_grant;

   always_comb begin
      w_sum        = '0;
      w_expire     = '0;
      w_miss_lanes = '0;
      w_grant_vld  = 1'b0;
      w_grant_lane = '0;
      w_free_vld   = 1'b0;
      w_free_slot  = '0;
      // Sum kept at 11 bits so a note near the bottom can never wrap back to the top.
      for (int k = 0; k < 4; k++) begin
         w_sum[k]    = {1'b0, r_y[k]} + L_SPEED;
         w_expire[k] = r_active[k] && (w_sum[k] >= L_Y_MAX);
         if (w_expire[k])
            w_miss_lanes[r_lane[k]] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         if (!w_grant_vld && r_pending[r_rr + 2'(i)]) begin
            w_grant_vld  = 1'b1;
            w_grant_lane = r_rr + 2'(i);
         end
      end
      for (int k = 3; k >= 0; k--) begin
         if (!r_active[k]) begin
            w_free_vld  = 1'b1;
            w_free_slot = 2'(k);
         end
      end
      w_grant = w_grant_vld && w_free_vld;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_active    <= '0;
         r_lane      <= '0;
         r_y         <= {4{L_Y_TOP}};
         r_pending   <= '0;
         r_rr        <= '0;
         r_miss_acc  <= '0;
         r_miss      <= '0;
         r_pass_done <= 1'b0;
      end else begin
         r_miss      <= '0;
         r_pass_done <= 1'b0;
         r_pending   <= r_pending | spawn_req;
         case (r_state)
            IDLE: begin
               if (frame_tick)
                  r_state <= ADVANCE;
            end
            ADVANCE: begin
               for (int k = 0; k < 4; k++) begin
                  if (w_expire[k]) begin
                     r_active[k] <= 1'b0;
                     r_y[k]      <= L_Y_TOP;
                  end else if (r_active[k]) begin
                     r_y[k]      <= w_sum[k][9:0];
                  end
               end
               r_miss_acc <= w_miss_lanes;
               r_state    <= SPAWN;
            end
            SPAWN: begin
               // A request landing on its own grant cycle re-arms pending for the next pass.
               if (w_grant) begin
                  r_active[w_free_slot] <= 1'b1;
                  r_lane[w_free_slot]   <= w_grant_lane;
                  r_y[w_free_slot]      <= L_Y_TOP;
                  r_pending             <= (r_pending & ~(4'b0001 << w_grant_lane)) | spawn_req;
                  r_rr                  <= w_grant_lane + 2'd1;
               end
               r_miss      <= r_miss_acc;
               r_pass_done <= 1'b1;
               r_state     <= DONE;
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef LANE_SCHED_MISS_CNT_EN
   function automatic logic [2:0] pop4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {6'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   logic [7:0] r_miss_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_miss_count <= '0;
      else if (r_state == DONE)
         r_miss_count <= sat_add8(r_miss_count, pop4(r_miss));
   end

   assign miss_count = r_miss_count;
`endif

   assign slot_active = r_active;
   assign slot_lane   = r_lane;
   assign slot_y      = r_y;
   assign miss        = r_miss;
   assign pass_done   = r_pass_done;
   assign full        = &r_active;
   assign overrun     = frame_tick && (r_state != IDLE);

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler: a slot/lane model predicts each pass, a monitor
// compares on every pass_done; directed scenarios plus randomized spawn/tick traffic.
module tb_lane_scheduler;

   localparam int SPEED = 5;
   localparam int Y_TOP = 35;
   localparam int Y_MAX = 500;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic [3:0]  spawn_req;
   logic [3:0]  slot_active;
   logic [7:0]  slot_lane;
   logic [39:0] slot_y;
   logic [3:0]  miss;
   logic        full;
   logic        pass_done;
   logic        overrun;
`ifdef LANE_SCHED_MISS_CNT_EN
   logic [7:0]  miss_count;
`endif

   lane_scheduler #(.SPEED(SPEED), .Y_TOP(Y_TOP), .Y_MAX(Y_MAX)) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .spawn_req   (spawn_req),
      .slot_active (slot_active),
      .slot_lane   (slot_lane),
      .slot_y      (slot_y),
      .miss        (miss),
      .full        (full),
      .pass_done   (pass_done),
      .overrun     (overrun)
`ifdef LANE_SCHED_MISS_CNT_EN
      ,
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  act;
      logic [7:0]  lane;
      logic [39:0] y;
      logic [3:0]  miss;
   } exp_t;

   exp_t sb_q[$];

   int m_act[4];
   int m_lane[4];
   int m_y[4];
   int m_pend[4];
   int m_rr;
   int mc_exp;
   int passes_exp;
   int passes_seen;
   int ov_seen;
   int checks;
   int errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         m_act[s]  = 0;
         m_lane[s] = 0;
         m_y[s]    = Y_TOP;
         m_pend[s] = 0;
      end
      m_rr   = 0;
      mc_exp = 0;
   endtask

   // One frame: notes fall, those reaching the bottom are missed, then one lane may spawn.
   task automatic model_pass(output exp_t e);
      int mbits;
      int nmiss;
      int done;
      int free;
      int l;
      mbits = 0;
      nmiss = 0;
      for (int s = 0; s < 4; s++) begin
         if (m_act[s] != 0) begin
            if (m_y[s] + SPEED >= Y_MAX) begin
               m_act[s] = 0;
               m_y[s]   = Y_TOP;
               if (((mbits >> m_lane[s]) & 1) == 0) nmiss++;
               mbits = mbits | (1 << m_lane[s]);
            end else begin
               m_y[s] = m_y[s] + SPEED;
            end
         end
      end
      done = 0;
      for (int i = 0; i < 4; i++) begin
         l = (m_rr + i) % 4;
         if (done == 0 && m_pend[l] != 0) begin
            done = 1;
            free = -1;
            for (int s = 0; s < 4; s++)
               if (m_act[s] == 0 && free < 0) free = s;
            if (free >= 0) begin
               m_act[free]  = 1;
               m_lane[free] = l;
               m_y[free]    = Y_TOP;
               m_pend[l]    = 0;
               m_rr         = (l + 1) % 4;
            end
         end
      end
      mc_exp = (mc_exp + nmiss > 255) ? 255 : mc_exp + nmiss;
      e.act  = '0;
      e.lane = '0;
      e.y    = '0;
      for (int s = 0; s < 4; s++) begin
         e.act[s] = (m_act[s] != 0);
         if (m_act[s] != 0) e.lane[2*s +: 2] = 2'(m_lane[s]);
         e.y[10*s +: 10] = 10'(m_y[s]);
      end
      e.miss = 4'(mbits);
   endtask

   exp_t       mon_e;
   logic [7:0] mon_mask;

   always @(negedge clk) begin
      #2;
      if (overrun === 1'b1) ov_seen++;
      if (reset === 1'b0) begin
         if (pass_done === 1'b1) begin
            passes_seen++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pass_done: got pass_done=1 required no pass");
            end else begin
               mon_e    = sb_q.pop_front();
               mon_mask = '0;
               for (int s = 0; s < 4; s++)
                  if (mon_e.act[s]) mon_mask[2*s +: 2] = 2'b11;
               chk("slot_active", slot_active, mon_e.act);
               chk("slot_lane", slot_lane & mon_mask, mon_e.lane);
               chk("slot_y", slot_y, mon_e.y);
               chk("miss", miss, mon_e.miss);
               chk("full", full, &mon_e.act);
            end
         end else if (miss !== 4'b0) begin
            checks++;
            errors++;
            $display("FAIL miss_outside_done: got %0h required 0", miss);
         end
      end
   end

   task automatic do_spawn(input logic [3:0] mask);
      @(negedge clk);
      spawn_req = mask;
      for (int l = 0; l < 4; l++)
         if (mask[l]) m_pend[l] = 1;
      @(negedge clk);
      spawn_req = '0;
   endtask

   // late is driven during the SPAWN cycle of this pass.
   task automatic do_tick(input logic [3:0] late);
      exp_t e;
      bit   seen;
      @(negedge clk);
      frame_tick = 1'b1;
      model_pass(e);
      for (int l = 0; l < 4; l++)
         if (late[l]) m_pend[l] = 1;
      sb_q.push_back(e);
      passes_exp++;
      seen = 1'b0;
      for (int c = 1; c <= 8 && !seen; c++) begin
         @(negedge clk);
         if (c == 1) frame_tick = 1'b0;
         if (c == 2) spawn_req = late;
         if (c == 3) spawn_req = '0;
         if (pass_done === 1'b1) begin
            seen = 1'b1;
            chk("pass_latency", 64'(c), 64'd3);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL pass_timeout: got no pass_done required one within 8 cycles");
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [39:0] ey;
      for (int s = 0; s < 4; s++) ey[10*s +: 10] = 10'(Y_TOP);
      chk({tag, "_active"}, slot_active, 4'b0);
      chk({tag, "_lane"}, slot_lane, 8'b0);
      chk({tag, "_y"}, slot_y, ey);
      chk({tag, "_miss"}, miss, 4'b0);
      chk({tag, "_full"}, full, 1'b0);
      chk({tag, "_pass_done"}, pass_done, 1'b0);
      chk({tag, "_overrun"}, overrun, 1'b0);
`ifdef LANE_SCHED_MISS_CNT_EN
      chk({tag, "_miss_count"}, miss_count, 8'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish required finish before 500us");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      bit   seen;
      checks      = 0;
      errors      = 0;
      passes_exp  = 0;
      passes_seen = 0;
      ov_seen     = 0;
      model_reset();

      // Power-on reset with requests and ticks asserted that must be discarded.
      reset      = 1'b1;
      frame_tick = 1'b1;
      spawn_req  = 4'hF;
      repeat (3) @(negedge clk);
      frame_tick = 1'b0;
      spawn_req  = '0;
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      do_tick('0);
      do_spawn(4'b0001);
      do_tick('0);
      chk("first_note_active", slot_active, 4'b0001);
      chk("first_note_y", slot_y[9:0], 10'd35);

      repeat (93) do_tick('0);
      chk("note_expired", slot_active, 4'b0000);

      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst2");
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      do_spawn(4'hF);
      repeat (4) do_tick('0);
      chk("four_grants_lane", slot_lane, 8'b11_10_01_00);
      chk("four_grants_full", full, 1'b1);

      do_spawn(4'b0100);
      do_tick('0);
      chk("full_no_grant", slot_lane, 8'b11_10_01_00);
      repeat (89) do_tick('0);
      chk("freed_slot_lane2", slot_lane[1:0], 2'd2);
      chk("freed_slot_full", full, 1'b1);

      // Back-to-back ticks: second one must be flagged and ignored.
      @(negedge clk);
      frame_tick = 1'b1;
      #1;
      chk("overrun_first_tick", overrun, 1'b0);
      model_pass(e);
      sb_q.push_back(e);
      passes_exp++;
      @(negedge clk);
      #1;
      chk("overrun_second_tick", overrun, 1'b1);
      @(negedge clk);
      frame_tick = 1'b0;
      #1;
      chk("overrun_cleared", overrun, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
         if (pass_done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL overrun_pass_timeout: got no pass_done required one");
      end
      repeat (6) @(negedge clk);

      do_spawn(4'b0010);
      do_tick(4'b0010);
      do_tick('0);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 1) == 1) do_spawn(4'($urandom_range(0, 15)));
         do_tick(($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0);
      end

      // Reset landing in the SPAWN cycle must wipe everything, including the grant.
      do_spawn(4'hF);
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("rst_spawn");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      do_tick('0);
      do_spawn(4'b0001);
      do_tick('0);

      repeat (5) @(negedge clk);
      chk("pass_count", 64'(passes_seen), 64'(passes_exp));
      chk("overrun_count", 64'(ov_seen), 64'd1);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
`ifdef LANE_SCHED_MISS_CNT_EN
      chk("miss_count_final", miss_count, 8'(mc_exp));
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
